// File: rtl/vga_scan_ctrl.sv
// VGA scan generator and layer compositor: drives renderer row/column addresses, merges the
// registered layer pixels into 12-bit RGB with matched sync, and reports dino/obstacle overlap.
module vga_scan_ctrl #(
  parameter int unsigned PX_LATENCY = 1,
  parameter logic [11:0] DINO_RGB   = 12'h333,
  parameter logic [11:0] OBST_RGB   = 12'h555,
  parameter logic [11:0] SCENE_RGB  = 12'h777,
  parameter logic [11:0] BG_RGB     = 12'hFFF,
  // Frame geometry; defaults give 640x480@60 with a 25 MHz pixel clock.
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33
) (
  input  logic        clkdiv,
  input  logic        RESET,
  input  logic        px_dino,
  input  logic        px_obst,
  input  logic        px_scene,
  input  logic        game_status,
  output logic [8:0]  row_addr,
  output logic [9:0]  col_addr,
  output logic        fresh,
  output logic        hs,
  output logic        vs,
  output logic [11:0] rgb,
  output logic        collision
);

  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_LAST       = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST       = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [8:0] ROW_HOLD     = 9'(V_VISIBLE - 1);
  localparam logic [9:0] DRAIN_COL    = 10'd8;

  logic [9:0]          r_h_cnt, r_v_cnt;
  logic [9:0]          w_h_nxt, w_v_nxt;
  logic [8:0]          r_row;
  logic [9:0]          r_col;
  logic                r_fresh;
  logic [PX_LATENCY:0] r_act_sr, r_hs_sr, r_vs_sr;
  logic [11:0]         r_rgb;
  logic                r_hit, r_collision;
  logic                w_active, w_hs_raw, w_vs_raw, w_act_d, w_drain, w_v_vis_nxt;

  always_comb begin
    w_h_nxt = r_h_cnt + 10'd1;
    w_v_nxt = r_v_cnt;
    if (r_h_cnt == H_LAST) begin
      w_h_nxt = '0;
      w_v_nxt = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
    end
  end

  assign w_v_vis_nxt = (w_v_nxt < V_VIS);
  assign w_active    = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
  assign w_hs_raw    = !((r_h_cnt >= H_SYNC_FIRST) && (r_h_cnt <= H_SYNC_LAST));
  assign w_vs_raw    = !((r_v_cnt >= V_SYNC_FIRST) && (r_v_cnt <= V_SYNC_LAST));
  // Active flag lined up with the renderer pixels arriving this cycle.
  assign w_act_d     = r_act_sr[PX_LATENCY-1];
  assign w_drain     = (r_v_cnt == V_VIS) && (r_h_cnt == DRAIN_COL);

  always_ff @(posedge clkdiv or posedge RESET) begin
    if (RESET) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_fresh <= 1'b0;
    end else begin
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
      r_col   <= w_h_nxt;
      r_row   <= w_v_vis_nxt ? w_v_nxt[8:0] : ROW_HOLD;
      r_fresh <= w_v_vis_nxt;
    end
  end

  always_ff @(posedge clkdiv or posedge RESET) begin
    if (RESET) begin
      r_act_sr <= '0;
      r_hs_sr  <= '1;
      r_vs_sr  <= '1;
      r_rgb    <= '0;
    end else begin
      r_act_sr <= {r_act_sr[PX_LATENCY-1:0], w_active};
      r_hs_sr  <= {r_hs_sr[PX_LATENCY-1:0], w_hs_raw};
      r_vs_sr  <= {r_vs_sr[PX_LATENCY-1:0], w_vs_raw};
      if (!w_act_d)      r_rgb <= 12'h000;
      else if (px_dino)  r_rgb <= DINO_RGB;
      else if (px_obst)  r_rgb <= OBST_RGB;
      else if (px_scene) r_rgb <= SCENE_RGB;
      else               r_rgb <= BG_RGB;
    end
  end

  // Report and clear once per frame after the last visible pixel has left the pipeline.
  always_ff @(posedge clkdiv or posedge RESET) begin
    if (RESET) begin
      r_hit       <= 1'b0;
      r_collision <= 1'b0;
    end else if (w_drain) begin
      r_collision <= r_hit;
      r_hit       <= 1'b0;
    end else begin
      r_collision <= 1'b0;
      if (w_act_d && px_dino && px_obst && game_status) r_hit <= 1'b1;
    end
  end

  assign row_addr  = r_row;
  assign col_addr  = r_col;
  assign fresh     = r_fresh;
  assign hs        = r_hs_sr[PX_LATENCY];
  assign vs        = r_vs_sr[PX_LATENCY];
  assign rgb       = r_rgb;
  assign collision = r_collision;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: a short-frame instance with a behavioural renderer and a default
// 640x480 instance, both compared every cycle against a cycle-count reference model.
module tb_vga_scan_ctrl;

  localparam int LAT     = 2;
  localparam int S_HVIS  = 40;
  localparam int S_HFP   = 4;
  localparam int S_HSYNC = 8;
  localparam int S_HBP   = 6;
  localparam int S_VVIS  = 30;
  localparam int S_VFP   = 3;
  localparam int S_VSYNC = 2;
  localparam int S_VBP   = 5;
  localparam int S_HT    = S_HVIS + S_HFP + S_HSYNC + S_HBP;
  localparam int S_VT    = S_VVIS + S_VFP + S_VSYNC + S_VBP;
  localparam int S_FRAME = S_HT * S_VT;
  localparam int D_HT    = 800;
  localparam int D_VT    = 525;

  localparam logic [11:0] C_DINO  = 12'h333;
  localparam logic [11:0] C_OBST  = 12'h555;
  localparam logic [11:0] C_SCENE = 12'h777;
  localparam logic [11:0] C_BG    = 12'hFFF;

  localparam int M_SCENE = 0;
  localparam int M_RAND  = 1;
  localparam int M_SPOT  = 2;
  localparam int M_NONE  = 3;

  logic clkdiv, rst, rst2, gs;
  logic s_px_dino, s_px_obst, s_px_scene;
  logic [8:0] s_row, d_row;
  logic [9:0] s_col, d_col;
  logic s_fresh, s_hs, s_vs, s_coll, d_fresh, d_hs, d_vs, d_coll;
  logic [11:0] s_rgb, d_rgb;
  logic [2:0] rend_q [LAT];

  int mode, pr, pc;
  int unsigned seed_d, seed_o, seed_s;
  int n, n2, pulse_cnt, checks, errors;
  bit acc, pulse_next;

  vga_scan_ctrl #(
    .PX_LATENCY(LAT), .H_VISIBLE(S_HVIS), .H_FRONT(S_HFP), .H_SYNC(S_HSYNC), .H_BACK(S_HBP),
    .V_VISIBLE(S_VVIS), .V_FRONT(S_VFP), .V_SYNC(S_VSYNC), .V_BACK(S_VBP)
  ) u_small (
    .clkdiv(clkdiv), .RESET(rst), .px_dino(s_px_dino), .px_obst(s_px_obst),
    .px_scene(s_px_scene), .game_status(gs), .row_addr(s_row), .col_addr(s_col),
    .fresh(s_fresh), .hs(s_hs), .vs(s_vs), .rgb(s_rgb), .collision(s_coll)
  );

  vga_scan_ctrl u_full (
    .clkdiv(clkdiv), .RESET(rst2), .px_dino(1'b0), .px_obst(1'b0), .px_scene(1'b1),
    .game_status(1'b0), .row_addr(d_row), .col_addr(d_col), .fresh(d_fresh), .hs(d_hs),
    .vs(d_vs), .rgb(d_rgb), .collision(d_coll)
  );

  initial begin
    clkdiv = 1'b0;
    forever #5 clkdiv = ~clkdiv;
  end

  function automatic bit pat(int unsigned seed, int r, int c);
    logic [31:0] x;
    x = (32'(r) * 32'd977 + 32'(c) * 32'd131 + seed) * 32'd2654435761;
    return x[20];
  endfunction

  function automatic bit lyr_dino(int r, int c);
    if (mode == M_RAND) return pat(seed_d, r, c);
    if (mode == M_SPOT) return (r == pr) && (c == pc);
    return 1'b0;
  endfunction

  function automatic bit lyr_obst(int r, int c);
    if (mode == M_RAND) return pat(seed_o, r, c);
    if (mode == M_SPOT) return (r == pr) && (c == pc);
    return 1'b0;
  endfunction

  function automatic bit lyr_scene(int r, int c);
    if (mode == M_SCENE) return 1'b1;
    if (mode == M_RAND || mode == M_SPOT) return pat(seed_s, r, c);
    return 1'b0;
  endfunction

  function automatic logic [11:0] colour(int r, int c);
    if (lyr_dino(r, c))  return C_DINO;
    if (lyr_obst(r, c))  return C_OBST;
    if (lyr_scene(r, c)) return C_SCENE;
    return C_BG;
  endfunction

  // Renderer stand-in: registered layer pixels, LAT clocks after the address.
  always @(posedge clkdiv or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) rend_q[i] <= 3'b000;
    end else begin
      rend_q[0] <= {lyr_dino(int'(s_row), int'(s_col)), lyr_obst(int'(s_row), int'(s_col)),
                    lyr_scene(int'(s_row), int'(s_col))};
      for (int i = 1; i < LAT; i++) rend_q[i] <= rend_q[i-1];
    end
  end
  assign {s_px_dino, s_px_obst, s_px_scene} = rend_q[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (n=%0d n2=%0d)", tag, obs, exp, n, n2);
    end
  endtask

  task automatic step();
    int h, v, a, ah, av;
    logic exp_hs, exp_vs;
    logic [11:0] exp_rgb;
    @(posedge clkdiv);
    if (!rst) n++;
    if (!rst2) n2++;
    @(negedge clkdiv);
    h = n % S_HT;
    v = (n / S_HT) % S_VT;
    exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 12'h000;
    if (n >= LAT + 1) begin
      a = n - LAT - 1; ah = a % S_HT; av = (a / S_HT) % S_VT;
      exp_hs = !(ah >= S_HVIS + S_HFP && ah < S_HVIS + S_HFP + S_HSYNC);
      exp_vs = !(av >= S_VVIS + S_VFP && av < S_VVIS + S_VFP + S_VSYNC);
      if (ah < S_HVIS && av < S_VVIS) exp_rgb = colour(av, ah);
    end
    chk("s_col", 32'(s_col), 32'(h));
    chk("s_row", 32'(s_row), 32'((v < S_VVIS) ? v : S_VVIS - 1));
    chk("s_fresh", 32'(s_fresh), 32'((n >= 1) && (v < S_VVIS)));
    chk("s_hs", 32'(s_hs), 32'(exp_hs));
    chk("s_vs", 32'(s_vs), 32'(exp_vs));
    chk("s_rgb", 32'(s_rgb), 32'(exp_rgb));
    chk("s_collision", 32'(s_coll), 32'(pulse_next));
    if (s_coll) pulse_cnt++;
    if (h == 8 && v == S_VVIS) begin
      pulse_next = acc;
      acc = 1'b0;
    end else begin
      pulse_next = 1'b0;
      if (n >= LAT) begin
        a = n - LAT; ah = a % S_HT; av = (a / S_HT) % S_VT;
        if (ah < S_HVIS && av < S_VVIS && lyr_dino(av, ah) && lyr_obst(av, ah) && gs) acc = 1'b1;
      end
    end
    // Full-size instance: scene layer tied high, so visible pixels show the scene colour.
    h = n2 % D_HT;
    v = (n2 / D_HT) % D_VT;
    exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 12'h000;
    if (n2 >= 2) begin
      a = n2 - 2; ah = a % D_HT; av = (a / D_HT) % D_VT;
      exp_hs = !(ah >= 656 && ah <= 751);
      exp_vs = !(av >= 490 && av <= 491);
      if (ah < 640 && av < 480) exp_rgb = C_SCENE;
    end
    chk("d_col", 32'(d_col), 32'(h));
    chk("d_row", 32'(d_row), 32'((v < 480) ? v : 479));
    chk("d_fresh", 32'(d_fresh), 32'((n2 >= 1) && (v < 480)));
    chk("d_hs", 32'(d_hs), 32'(exp_hs));
    chk("d_vs", 32'(d_vs), 32'(exp_vs));
    chk("d_rgb", 32'(d_rgb), 32'(exp_rgb));
    chk("d_collision", 32'(d_coll), 32'd0);
  endtask

  task automatic set_mode(input int m, input logic g);
    mode = m;
    gs = g;
    seed_d = $urandom; seed_o = $urandom; seed_s = $urandom;
  endtask

  initial begin
    checks = 0; errors = 0; n = 0; n2 = 0; pulse_cnt = 0;
    acc = 1'b0; pulse_next = 1'b0;
    pr = 0; pc = 0;
    rst = 1'b1; rst2 = 1'b1;
    set_mode(M_SCENE, 1'b1);
    repeat (3) step();
    rst = 1'b0; rst2 = 1'b0;

    repeat (S_FRAME) step();
    set_mode(M_RAND, 1'b1);
    repeat (S_FRAME) step();
    set_mode(M_RAND, 1'b0);
    pulse_cnt = 0;
    repeat (S_FRAME) step();
    chk("pulses_paused_random", 32'(pulse_cnt), 32'd0);

    set_mode(M_SPOT, 1'b1);
    pr = int'($urandom_range(S_VVIS - 10, S_VVIS - 1));
    pc = int'($urandom_range(0, S_HVIS - 1));
    pulse_cnt = 0;
    repeat (S_FRAME) step();
    chk("pulses_single_overlap", 32'(pulse_cnt), 32'd1);
    set_mode(M_NONE, 1'b1);
    pulse_cnt = 0;
    repeat (S_FRAME) step();
    chk("pulses_next_frame", 32'(pulse_cnt), 32'd0);

    set_mode(M_SPOT, 1'b0);
    pulse_cnt = 0;
    repeat (S_FRAME) step();
    chk("pulses_overlap_paused", 32'(pulse_cnt), 32'd0);

    set_mode(M_SPOT, 1'b1);
    pr = 3;
    pc = int'($urandom_range(0, S_HVIS - 1));
    repeat (20 * S_HT) step();
    rst = 1'b1;
    #1;
    chk("rst_row", 32'(s_row), 32'd0);
    chk("rst_col", 32'(s_col), 32'd0);
    chk("rst_fresh", 32'(s_fresh), 32'd0);
    chk("rst_hs", 32'(s_hs), 32'd1);
    chk("rst_vs", 32'(s_vs), 32'd1);
    chk("rst_rgb", 32'(s_rgb), 32'd0);
    chk("rst_collision", 32'(s_coll), 32'd0);
    n = 0; acc = 1'b0; pulse_next = 1'b0; pulse_cnt = 0;
    repeat (2) step();
    set_mode(M_NONE, 1'b1);
    rst = 1'b0;
    repeat (S_FRAME) step();
    chk("pulses_after_reset", 32'(pulse_cnt), 32'd0);

    set_mode(M_RAND, 1'b1);
    repeat (S_FRAME) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
